// File: rtl/wb_ram_arb_pkg.sv
// Shared definitions for the two-master Wishbone RAM arbiter: state encoding and default widths.
package wb_ram_arb_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_SEL_WIDTH  = DEFAULT_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/wb_ram_arb_grant.sv
// Grant FSM for the two-master arbiter: next-state, tie-break and the state register.
// Define WB_RAM_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise master 0 always wins a tie.
module wb_ram_arb_grant
  import wb_ram_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       m0_cyc_i,
  input  logic       m1_cyc_i,
  output arb_state_e state_o
);

  arb_state_e state_q;
  logic       tie_to_m1;

`ifdef WB_RAM_ARB_ROUND_ROBIN_EN
  logic last_q;  // 1 when master 1 held the bus most recently
  assign tie_to_m1 = ~last_q;
`else
  assign tie_to_m1 = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
`ifdef WB_RAM_ARB_ROUND_ROBIN_EN
      last_q  <= 1'b1;
`endif
    end else begin
      case (state_q)
        GNT0: if (!m0_cyc_i) state_q <= m1_cyc_i ? GNT1 : IDLE;
        GNT1: if (!m1_cyc_i) state_q <= m0_cyc_i ? GNT0 : IDLE;
        // IDLE and the unused encoding 2'd3 both arbitrate from scratch
        default: begin
          if (m0_cyc_i && m1_cyc_i) state_q <= tie_to_m1 ? GNT1 : GNT0;
          else if (m0_cyc_i)        state_q <= GNT0;
          else if (m1_cyc_i)        state_q <= GNT1;
          else                      state_q <= IDLE;
        end
      endcase
`ifdef WB_RAM_ARB_ROUND_ROBIN_EN
      if (state_q == GNT0)      last_q <= 1'b0;
      else if (state_q == GNT1) last_q <= 1'b1;
`endif
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/wb_ram_arbiter.sv
// Two-master Wishbone arbiter in front of a single RAM slave; pure muxing around the grant FSM.
// Optional build macro WB_RAM_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking.
module wb_ram_arbiter
  import wb_ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int SEL_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,

  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [SEL_WIDTH-1:0]  m0_sel_i,
  input  logic [31:0]           m0_adr_i,
  input  logic [DATA_WIDTH-1:0] m0_dat_i,
  output logic                  m0_ack_o,
  output logic [DATA_WIDTH-1:0] m0_dat_o,

  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [SEL_WIDTH-1:0]  m1_sel_i,
  input  logic [31:0]           m1_adr_i,
  input  logic [DATA_WIDTH-1:0] m1_dat_i,
  output logic                  m1_ack_o,
  output logic [DATA_WIDTH-1:0] m1_dat_o,

  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [SEL_WIDTH-1:0]  s_sel_o,
  output logic [31:0]           s_adr_o,
  output logic [DATA_WIDTH-1:0] s_dat_o,
  input  logic                  s_ack_i,
  input  logic [DATA_WIDTH-1:0] s_dat_i
);

  arb_state_e state;
  logic       gnt0;
  logic       gnt1;

  wb_ram_arb_grant u_grant (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .m0_cyc_i (m0_cyc_i),
    .m1_cyc_i (m1_cyc_i),
    .state_o  (state)
  );

  assign gnt0 = (state == GNT0);
  assign gnt1 = (state == GNT1);

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    if (gnt0) begin
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_stb_i;
      s_we_o  = m0_we_i;
      s_sel_o = m0_sel_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
    end else if (gnt1) begin
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_stb_i;
      s_we_o  = m1_we_i;
      s_sel_o = m1_sel_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
    end
  end

  // Acks seen while idle (e.g. after a reset abort) go nowhere
  assign m0_ack_o = gnt0 & s_ack_i;
  assign m1_ack_o = gnt1 & s_ack_i;
  assign m0_dat_o = gnt0 ? s_dat_i : '0;
  assign m1_dat_o = gnt1 ? s_dat_i : '0;

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Directed self-checking bench for wb_ram_arbiter; grant is inferred from the forwarded address.
module tb_wb_ram_arbiter;

  localparam int DW = 32;
  localparam int SW = 4;
  localparam logic [31:0] A0 = 32'h3000_0010;
  localparam logic [31:0] A1 = 32'h4000_0020;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i;
  logic          m0_cyc_i, m0_stb_i, m0_we_i;
  logic [SW-1:0] m0_sel_i;
  logic [31:0]   m0_adr_i;
  logic [DW-1:0] m0_dat_i;
  logic          m0_ack_o;
  logic [DW-1:0] m0_dat_o;
  logic          m1_cyc_i, m1_stb_i, m1_we_i;
  logic [SW-1:0] m1_sel_i;
  logic [31:0]   m1_adr_i;
  logic [DW-1:0] m1_dat_i;
  logic          m1_ack_o;
  logic [DW-1:0] m1_dat_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [SW-1:0] s_sel_o;
  logic [31:0]   s_adr_o;
  logic [DW-1:0] s_dat_o;
  logic          s_ack_i;
  logic [DW-1:0] s_dat_i;

  int checks_cnt   = 0;
  int failures_cnt = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_ram_arbiter #(.DATA_WIDTH(DW), .SEL_WIDTH(SW)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_ack_o(m0_ack_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_ack_o(m1_ack_o), .m1_dat_o(m1_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      failures_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // 0 = idle, 1 = master 0 granted, 2 = master 1 granted, 3 = unrecognised
  function automatic logic [63:0] grant_code();
    if (s_adr_o == A0)      return 64'd1;
    else if (s_adr_o == A1) return 64'd2;
    else if (s_adr_o == 0)  return 64'd0;
    else                    return 64'd3;
  endfunction

  // advance past the next rising edge so new inputs can be driven
  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    wb_rst_i = 1'b1;
    step();
    step();
    wb_rst_i = 1'b0;
  endtask

  initial begin
    wb_rst_i = 1'b1;
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_sel_i = '0; m0_adr_i = A0; m0_dat_i = 32'h0000_00A0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_sel_i = '0; m1_adr_i = A1; m1_dat_i = 32'h0000_00B1;
    s_ack_i = 0; s_dat_i = '0;

    // reset state
    do_reset();
    settle();
    check("rst_grant", grant_code(), 0);
    check("rst_s_cyc", {63'd0, s_cyc_o}, 0);
    check("rst_acks",  {62'd0, m1_ack_o, m0_ack_o}, 0);

    // ack in IDLE is dropped
    s_ack_i = 1; s_dat_i = 32'h1234_5678;
    settle();
    check("idle_ack_drop", {62'd0, m1_ack_o, m0_ack_o}, 0);
    check("idle_dat_zero", {m1_dat_o, m0_dat_o}, 0);
    s_ack_i = 0;

    // single master read with 1-cycle arbitration latency
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_sel_i = 4'hF;
    settle();
    check("rd_arb_cycle_grant", grant_code(), 0);
    step();
    check("rd_grant0", grant_code(), 1);
    check("rd_s_stb", {63'd0, s_stb_o}, 1);
    check("rd_no_ack_yet", {62'd0, m1_ack_o, m0_ack_o}, 0);
    step();
    s_ack_i = 1; s_dat_i = 32'hDEAD_BEEF;
    settle();
    check("rd_m0_ack", {63'd0, m0_ack_o}, 1);
    check("rd_m0_dat", {32'd0, m0_dat_o}, 64'hDEAD_BEEF);
    check("rd_m1_ack", {63'd0, m1_ack_o}, 0);
    check("rd_m1_dat", {32'd0, m1_dat_o}, 0);
    step();
    s_ack_i = 0; s_dat_i = '0; m0_cyc_i = 0; m0_stb_i = 0;
    settle();
    check("rd_ack_one_cycle", {62'd0, m1_ack_o, m0_ack_o}, 0);
    step();
    check("rd_back_idle", grant_code(), 0);

    // tie from reset: m0 first, then m1 with no idle bubble
    do_reset();
    m0_cyc_i = 1; m1_cyc_i = 1;
    step();
    check("tie1_grant", grant_code(), 1);
    m0_cyc_i = 0;
    settle();
    check("tie1_hold_until_edge", grant_code(), 1);
    step();
    check("tie1_handover_m1", grant_code(), 2);
    m1_cyc_i = 0;
    step();
    check("tie1_idle", grant_code(), 0);
    m0_cyc_i = 1; m1_cyc_i = 1;
    step();
    check("tie2_grant", grant_code(), 1);
    m0_cyc_i = 0; m1_cyc_i = 0;
    step();
    check("tie2_idle", grant_code(), 0);
    m0_cyc_i = 1; m1_cyc_i = 1;
    step();
`ifdef WB_RAM_ARB_ROUND_ROBIN_EN
    check("tie3_rr_grant", grant_code(), 2);
`else
    check("tie3_fixed_grant", grant_code(), 1);
`endif

    // both masters request continuously with 1-cycle cyc gaps
    do_reset();
    m0_cyc_i = 1; m1_cyc_i = 1;
    step();
    check("alt_start_m0", grant_code(), 1);
    for (int i = 0; i < 3; i++) begin
      m0_cyc_i = 0;
      step();
      m0_cyc_i = 1;
      settle();
      check($sformatf("alt%0d_m1_on_gap", i), grant_code(), 2);
      step();
      check($sformatf("alt%0d_m0_loses_reassert", i), grant_code(), 2);
      m1_cyc_i = 0;
      step();
      m1_cyc_i = 1;
      settle();
      check($sformatf("alt%0d_m0_back", i), grant_code(), 1);
    end
    m0_cyc_i = 0; m1_cyc_i = 0;

    // hold: m1 does 3 back-to-back writes while m0 requests
    do_reset();
    m1_cyc_i = 1;
    step();
    check("hold_grant1", grant_code(), 2);
    m0_cyc_i = 1;
    m1_stb_i = 1; m1_we_i = 1; m1_sel_i = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      m1_dat_i = 32'hC0DE_0000 + 32'(i);
      s_ack_i = 1;
      settle();
      check($sformatf("hold_w%0d_grant", i), grant_code(), 2);
      check($sformatf("hold_w%0d_sel", i), {60'd0, s_sel_o}, 64'h3);
      check($sformatf("hold_w%0d_we", i), {63'd0, s_we_o}, 1);
      check($sformatf("hold_w%0d_dat", i), {32'd0, s_dat_o}, 64'hC0DE_0000 + 64'(i));
      check($sformatf("hold_w%0d_acks", i), {62'd0, m1_ack_o, m0_ack_o}, 64'h2);
      step();
    end
    s_ack_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_cyc_i = 0;
    settle();
    check("hold_still_m1", grant_code(), 2);
    step();
    check("hold_switch_m0", grant_code(), 1);
    m0_cyc_i = 0; m1_sel_i = '0;

    // reset mid-transfer aborts; late ack dropped
    do_reset();
    m0_cyc_i = 1; m0_stb_i = 1;
    step();
    check("abort_grant0", grant_code(), 1);
    wb_rst_i = 1;
    step();
    wb_rst_i = 0;
    s_ack_i = 1; s_dat_i = 32'hBAD0_0BAD;
    settle();
    check("abort_m0_ack", {63'd0, m0_ack_o}, 0);
    check("abort_idle", grant_code(), 0);
    check("abort_s_ctrl", {61'd0, s_cyc_o, s_stb_o, s_we_o}, 0);
    check("abort_s_sel_adr", {28'd0, s_sel_o, s_adr_o}, 0);
    check("abort_s_dat", {32'd0, s_dat_o}, 0);
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
    $finish;
  end

endmodule
